// File: rtl/reg_port_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_port_arb_pkg
// Purpose  : Shared widths, defaults and channel state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package reg_port_arb_pkg;

  localparam int IDX_W      = 5;
  localparam int DEF_REG_SZ = 32;
  localparam int DEF_TMO    = 15;

  typedef enum logic [1:0] {
    R_IDLE    = 2'd0,
    R_ASSERT  = 2'd1,
    R_RELEASE = 2'd2,
    R_DONE    = 2'd3
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_ASSERT  = 2'd1,
    W_RELEASE = 2'd2,
    W_DONE    = 2'd3
  } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/reg_port_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_port_arb_if
// Purpose  : Requester-side and regfile-side signals of the register port
//            arbiter; slave = arbiter view, master = surrounding logic view.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_port_arb_if import reg_port_arb_pkg::*; #(
  parameter int REG_SZ = DEF_REG_SZ,
  parameter int NRD    = 2
);

  logic [NRD-1:0]       rd_req;
  logic [NRD*IDX_W-1:0] rd_idx;
  logic [NRD-1:0]       rd_done;
  logic [REG_SZ-1:0]    rd_data;

  logic                 wr_req;
  logic [IDX_W-1:0]     wr_idx;
  logic [REG_SZ-1:0]    wr_data;
  logic                 wr_done;

  logic                 rf_re;
  logic [IDX_W-1:0]     rf_r_idx;
  logic                 rf_rack;
  logic [REG_SZ-1:0]    rf_dout;
  logic                 rf_we;
  logic [IDX_W-1:0]     rf_w_idx;
  logic [REG_SZ-1:0]    rf_din;
  logic                 rf_wack;

  logic                 err;
  logic                 busy;

  modport slave (
    input  rd_req, rd_idx, wr_req, wr_idx, wr_data, rf_rack, rf_dout, rf_wack,
    output rd_done, rd_data, wr_done, rf_re, rf_r_idx, rf_we, rf_w_idx, rf_din,
           err, busy
  );

  modport master (
    output rd_req, rd_idx, wr_req, wr_idx, wr_data, rf_rack, rf_dout, rf_wack,
    input  rd_done, rd_data, wr_done, rf_re, rf_r_idx, rf_we, rf_w_idx, rf_din,
           err, busy
  );

endinterface
`default_nettype wire

// File: rtl/reg_port_arb_rr.sv
`default_nettype none
// ============================================================================
// Module   : reg_port_arb_rr
// Purpose  : Round-robin picker; search starts at i_ptr and wraps.
// Revision : 1.0 - initial release
// ============================================================================
module reg_port_arb_rr #(
  parameter int NRD   = 2,
  parameter int PTR_W = 1
) (
  input  logic [NRD-1:0]   i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NRD-1:0]   o_gnt,
  output logic [PTR_W-1:0] o_gnt_idx,
  output logic             o_vld
);

  int w_j;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_vld     = 1'b0;
    w_j       = 0;
    for (int i = 0; i < NRD; i++) begin
      w_j = int'(i_ptr) + i;
      if (w_j >= NRD) w_j = w_j - NRD;
      for (int k = 0; k < NRD; k++) begin
        if (!o_vld && (k == w_j) && i_req[k]) begin
          o_vld     = 1'b1;
          o_gnt[k]  = 1'b1;
          o_gnt_idx = PTR_W'(k);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : reg_port_arb
// Purpose  : Arbitrates NRD read requesters and one writer onto a regfile
//            with four-phase ack handshakes and per-channel timeouts.
//            Option macro: REG_PORT_ARB_BYPASS_EN (same-index read served
//            from the pending write data instead of stalling).
// Revision : 1.0 - initial release
// ============================================================================
module reg_port_arb import reg_port_arb_pkg::*; #(
  parameter int REG_SZ = DEF_REG_SZ,
  parameter int NRD    = 2,
  parameter int TMO    = DEF_TMO
) (
  input  logic         clk,
  input  logic         rst,
  reg_port_arb_if.slave bus
);

  localparam int c_ptr_w = (NRD > 1) ? $clog2(NRD) : 1;
  localparam int c_cnt_w = $clog2(TMO + 1);

  rd_state_t          r_rstate, w_rnxt;
  wr_state_t          r_wstate, w_wnxt;

  logic [NRD-1:0]     w_win_gnt;
  logic [c_ptr_w-1:0] w_win_ptr;
  logic               w_win_vld;
  logic [IDX_W-1:0]   w_win_idx;
  logic [c_ptr_w-1:0] r_rptr, w_ptr_nxt;

  logic [NRD-1:0]     r_rgnt;
  logic [IDX_W-1:0]   r_r_idx;
  logic [REG_SZ-1:0]  r_rcap, r_rd_data, w_rdata_nxt;
  logic [c_cnt_w-1:0] r_rcnt, r_wcnt;
  logic               w_rcnt_exp, w_wcnt_exp;
  logic               w_rgo, w_cap_en, w_rdata_ld, w_rtmo;

  logic               w_wgo, w_wtmo;
  logic [IDX_W-1:0]   r_w_idx;
  logic [REG_SZ-1:0]  r_w_din;
  logic               r_err;

  logic               w_wr_fly, w_hit_pend, w_hit_fly, w_hazard;

  reg_port_arb_rr #(.NRD(NRD), .PTR_W(c_ptr_w)) u_rr (
    .i_req     (bus.rd_req),
    .i_ptr     (r_rptr),
    .o_gnt     (w_win_gnt),
    .o_gnt_idx (w_win_ptr),
    .o_vld     (w_win_vld)
  );

  always_comb begin
    w_win_idx = '0;
    for (int k = 0; k < NRD; k++) begin
      if (w_win_gnt[k]) w_win_idx = bus.rd_idx[k*IDX_W +: IDX_W];
    end
  end

  assign w_ptr_nxt = (w_win_ptr == c_ptr_w'(NRD - 1)) ? '0 : w_win_ptr + 1'b1;

  // A read must not overtake a write to the same register that is waiting or mid-handshake
  assign w_wr_fly   = (r_wstate == W_ASSERT) || (r_wstate == W_RELEASE);
  assign w_hit_pend = (r_wstate == W_IDLE) && bus.wr_req && (bus.wr_idx == w_win_idx);
  assign w_hit_fly  = w_wr_fly && (r_w_idx == w_win_idx);
  assign w_hazard   = w_hit_pend || w_hit_fly;

`ifdef REG_PORT_ARB_BYPASS_EN
  logic [REG_SZ-1:0] w_byp_data;
  assign w_byp_data = w_hit_fly ? r_w_din : bus.wr_data;
`endif

  assign w_rcnt_exp = (r_rcnt == c_cnt_w'(TMO - 1));
  assign w_wcnt_exp = (r_wcnt == c_cnt_w'(TMO - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstate <= R_IDLE;
      r_wstate <= W_IDLE;
    end else begin
      r_rstate <= w_rnxt;
      r_wstate <= w_wnxt;
    end
  end

  always_comb begin
    w_rnxt      = r_rstate;
    w_rgo       = 1'b0;
    w_cap_en    = 1'b0;
    w_rdata_ld  = 1'b0;
    w_rdata_nxt = '0;
    w_rtmo      = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (w_win_vld) begin
          if (w_win_idx == '0) begin
            w_rgo      = 1'b1;
            w_rdata_ld = 1'b1;
            w_rnxt     = R_DONE;
          end else if (w_hazard) begin
`ifdef REG_PORT_ARB_BYPASS_EN
            w_rgo       = 1'b1;
            w_rdata_ld  = 1'b1;
            w_rdata_nxt = w_byp_data;
            w_rnxt      = R_DONE;
`endif
          end else begin
            w_rgo  = 1'b1;
            w_rnxt = R_ASSERT;
          end
        end
      end
      R_ASSERT: begin
        if (bus.rf_rack) begin
          w_cap_en = 1'b1;
          w_rnxt   = R_RELEASE;
        end else if (w_rcnt_exp) begin
          w_rtmo     = 1'b1;
          w_rdata_ld = 1'b1;
          w_rnxt     = R_DONE;
        end
      end
      R_RELEASE: begin
        if (!bus.rf_rack) begin
          w_rdata_ld  = 1'b1;
          w_rdata_nxt = r_rcap;
          w_rnxt      = R_DONE;
        end else if (w_rcnt_exp) begin
          w_rtmo     = 1'b1;
          w_rdata_ld = 1'b1;
          w_rnxt     = R_DONE;
        end
      end
      default: w_rnxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_wnxt = r_wstate;
    w_wgo  = 1'b0;
    w_wtmo = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (bus.wr_req) begin
          if (bus.wr_idx == '0) begin
            w_wnxt = W_DONE;
          end else begin
            w_wgo  = 1'b1;
            w_wnxt = W_ASSERT;
          end
        end
      end
      W_ASSERT: begin
        if (bus.rf_wack) begin
          w_wnxt = W_RELEASE;
        end else if (w_wcnt_exp) begin
          w_wtmo = 1'b1;
          w_wnxt = W_DONE;
        end
      end
      W_RELEASE: begin
        if (!bus.rf_wack) begin
          w_wnxt = W_DONE;
        end else if (w_wcnt_exp) begin
          w_wtmo = 1'b1;
          w_wnxt = W_DONE;
        end
      end
      default: w_wnxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rptr    <= '0;
      r_rgnt    <= '0;
      r_r_idx   <= '0;
      r_rcap    <= '0;
      r_rd_data <= '0;
      r_rcnt    <= '0;
      r_w_idx   <= '0;
      r_w_din   <= '0;
      r_wcnt    <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_rgo) begin
        r_rgnt  <= w_win_gnt;
        r_r_idx <= w_win_idx;
        r_rptr  <= w_ptr_nxt;
      end
      if (w_cap_en)   r_rcap    <= bus.rf_dout;
      if (w_rdata_ld) r_rd_data <= w_rdata_nxt;
      // Each handshake phase gets its own TMO-cycle budget
      if (w_rnxt != r_rstate)
        r_rcnt <= '0;
      else if ((r_rstate == R_ASSERT) || (r_rstate == R_RELEASE))
        r_rcnt <= r_rcnt + 1'b1;
      if (w_wgo) begin
        r_w_idx <= bus.wr_idx;
        r_w_din <= bus.wr_data;
      end
      if (w_wnxt != r_wstate)
        r_wcnt <= '0;
      else if (w_wr_fly)
        r_wcnt <= r_wcnt + 1'b1;
      r_err <= w_rtmo | w_wtmo;
    end
  end

  assign bus.rf_re    = (r_rstate == R_ASSERT);
  assign bus.rf_r_idx = r_r_idx;
  assign bus.rd_done  = (r_rstate == R_DONE) ? r_rgnt : '0;
  assign bus.rd_data  = r_rd_data;
  assign bus.rf_we    = (r_wstate == W_ASSERT);
  assign bus.rf_w_idx = r_w_idx;
  assign bus.rf_din   = r_w_din;
  assign bus.wr_done  = (r_wstate == W_DONE);
  assign bus.err      = r_err;
  assign bus.busy     = (r_rstate != R_IDLE) || (r_wstate != W_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_reg_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_port_arb
// Purpose  : Directed bench for reg_port_arb with a queue-based scoreboard
//            and a regfile model that acks in the same cycle as the strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_port_arb;

  localparam int RSZ = 32;

  typedef struct {
    int          k;
    logic [31:0] data;
    int          due;
    logic        err;
  } rd_exp_t;

  typedef struct {
    int   due;
    logic err;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst;
  logic ack_en = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   re_cnt = 0;
  int   we_cnt = 0;
  int   base;

  rd_exp_t rq[$];
  wr_exp_t wq[$];
  rd_exp_t re_e;
  wr_exp_t we_e;

  logic [RSZ-1:0] mem [32];

  reg_port_arb_if #(.REG_SZ(RSZ), .NRD(2)) bus ();

  reg_port_arb #(.REG_SZ(RSZ), .NRD(2), .TMO(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.rf_re) re_cnt <= re_cnt + 1;
    if (bus.rf_we) we_cnt <= we_cnt + 1;
  end

  // Regfile model: ack follows the strobe combinationally when enabled
  assign bus.rf_rack = bus.rf_re & ack_en;
  assign bus.rf_wack = bus.rf_we & ack_en;
  assign bus.rf_dout = mem[bus.rf_r_idx];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hC0DE_0000 + i;
    end else if (bus.rf_we && ack_en) begin
      mem[bus.rf_w_idx] <= bus.rf_din;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rd_done != '0) begin
      if (rq.size() == 0) begin
        chk("rd_unexpected", bus.rd_done, 64'd0);
      end else begin
        re_e = rq.pop_front();
        chk("rd_who",  bus.rd_done, 64'd1 << re_e.k);
        chk("rd_data", bus.rd_data, re_e.data);
        chk("rd_lat",  cyc,         re_e.due);
        chk("rd_err",  bus.err,     re_e.err);
      end
    end
    if (bus.wr_done) begin
      if (wq.size() == 0) begin
        chk("wr_unexpected", bus.wr_done, 64'd0);
      end else begin
        we_e = wq.pop_front();
        chk("wr_lat", cyc,     we_e.due);
        chk("wr_err", bus.err, we_e.err);
      end
    end
    if (bus.err && (bus.rd_done == '0) && !bus.wr_done)
      chk("err_alone", bus.err, 64'd0);
  end

  task automatic push_rd(input int k, input logic [31:0] data, input int lat, input logic err);
    rd_exp_t e;
    e.k    = k;
    e.data = data;
    e.due  = cyc + lat;
    e.err  = err;
    rq.push_back(e);
  endtask

  task automatic issue_rd(input int k, input logic [4:0] idx, input logic [31:0] data,
                          input int lat, input logic err);
    bus.rd_idx[5*k +: 5] = idx;
    bus.rd_req[k]        = 1'b1;
    push_rd(k, data, lat, err);
  endtask

  task automatic issue_wr(input logic [4:0] idx, input logic [31:0] data, input int lat);
    wr_exp_t e;
    bus.wr_idx  = idx;
    bus.wr_data = data;
    bus.wr_req  = 1'b1;
    e.due = cyc + lat;
    e.err = 1'b0;
    wq.push_back(e);
  endtask

  task automatic wait_rd(input int k, input int lim);
    int n = 0;
    while (!bus.rd_done[k] && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rd_done[k]) begin
      total++;
      bad++;
      $display("FAIL rd_wait_%0d: no rd_done after %0d cycles, want one", k, lim);
    end
    bus.rd_req[k] = 1'b0;
  endtask

  task automatic wait_wr(input int lim);
    int n = 0;
    while (!bus.wr_done && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!bus.wr_done) begin
      total++;
      bad++;
      $display("FAIL wr_wait: no wr_done after %0d cycles, want one", lim);
    end
    bus.wr_req = 1'b0;
  endtask

  initial begin
    int nd;
    int n;
    rst         = 1'b0;
    bus.rd_req  = '0;
    bus.rd_idx  = '0;
    bus.wr_req  = 1'b0;
    bus.wr_idx  = '0;
    bus.wr_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_rf_re",    bus.rf_re,    64'd0);
    chk("rst_rf_we",    bus.rf_we,    64'd0);
    chk("rst_rf_r_idx", bus.rf_r_idx, 64'd0);
    chk("rst_rf_w_idx", bus.rf_w_idx, 64'd0);
    chk("rst_rf_din",   bus.rf_din,   64'd0);
    chk("rst_rd_data",  bus.rd_data,  64'd0);
    chk("rst_rd_done",  bus.rd_done,  64'd0);
    chk("rst_wr_done",  bus.wr_done,  64'd0);
    chk("rst_err",      bus.err,      64'd0);
    chk("rst_busy",     bus.busy,     64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Write then read back through the regfile
    issue_wr(5'd3, 32'h1234, 3);
    wait_wr(20);
    @(negedge clk);
    issue_rd(0, 5'd3, 32'h1234, 3, 1'b0);
    wait_rd(0, 20);
    @(negedge clk);

    // Index 0 never reaches the regfile
    base = re_cnt;
    issue_rd(1, 5'd0, 32'h0, 1, 1'b0);
    wait_rd(1, 20);
    chk("idx0_rd_no_re", re_cnt - base, 64'd0);
    @(negedge clk);
    base = we_cnt;
    issue_wr(5'd0, 32'hFF, 1);
    wait_wr(20);
    chk("idx0_wr_no_we", we_cnt - base, 64'd0);
    chk("idx0_rf_din",   bus.rf_din,    64'h1234);
    @(negedge clk);

    // Same-cycle write and read of index 5
    base = re_cnt;
    issue_wr(5'd5, 32'hAA, 3);
`ifdef REG_PORT_ARB_BYPASS_EN
    issue_rd(0, 5'd5, 32'hAA, 1, 1'b0);
`else
    issue_rd(0, 5'd5, 32'hAA, 6, 1'b0);
`endif
    fork
      wait_wr(20);
      wait_rd(0, 20);
    join
`ifdef REG_PORT_ARB_BYPASS_EN
    chk("byp_no_re", re_cnt - base, 64'd0);
`endif
    @(negedge clk);

    // Read timeout with the ack stuck low
    ack_en = 1'b0;
    base   = re_cnt;
    issue_rd(0, 5'd7, 32'h0, 16, 1'b1);
    wait_rd(0, 40);
    chk("tmo_re_cycles", re_cnt - base, 64'd15);
    ack_en = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in the middle of a read
    ack_en            = 1'b0;
    bus.rd_idx[4:0]   = 5'd9;
    bus.rd_req[0]     = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rf_re",  bus.rf_re, 64'd1);
    chk("mid_busy",   bus.busy,  64'd1);
    rst = 1'b0;
    #1;
    chk("rstmid_rf_re",    bus.rf_re,    64'd0);
    chk("rstmid_busy",     bus.busy,     64'd0);
    chk("rstmid_rd_done",  bus.rd_done,  64'd0);
    chk("rstmid_rf_r_idx", bus.rf_r_idx, 64'd0);
    bus.rd_req = '0;
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    ack_en = 1'b1;
    @(negedge clk);

    // Both requesters held: grants alternate starting from requester 0
    bus.rd_idx = {5'd11, 5'd10};
    bus.rd_req = 2'b11;
    push_rd(0, 32'hC0DE_000A, 3,  1'b0);
    push_rd(1, 32'hC0DE_000B, 7,  1'b0);
    push_rd(0, 32'hC0DE_000A, 11, 1'b0);
    push_rd(1, 32'hC0DE_000B, 15, 1'b0);
    nd = 0;
    n  = 0;
    while (nd < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.rd_done != '0) nd++;
    end
    if (nd < 4) begin
      total++;
      bad++;
      $display("FAIL rr_wait: got %0d rd_done pulses, want 4", nd);
    end
    bus.rd_req = '0;

    repeat (6) @(negedge clk);
    chk("rd_queue_left", rq.size(), 64'd0);
    chk("wr_queue_left", wq.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, want end before 200000");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/reg_port_arb.md
REG_PORT_ARB -- requirements
Module: reg_port_arb

Interface
REQ-001 SHALL have parameter REG_SZ, default 32, data width of register values.
REQ-002 SHALL have parameter NRD, default 2, number of read requesters.
REQ-003 SHALL have parameter TMO, default 15, ack-timeout limit in cycles.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port rd_req  in  NRD  per-requester read request level.
REQ-007 SHALL have port rd_idx  in  NRD*5  per-requester register index, requester k at bits [5k+4:5k].
REQ-008 SHALL have port rd_done  out  NRD  one-cycle completion pulse to the served requester.
REQ-009 SHALL have port rd_data  out  REG_SZ  read result, valid in the rd_done cycle and held until the next rd_done.
REQ-010 SHALL have ports wr_req in 1, wr_idx in 5, wr_data in REG_SZ, and wr_done out 1, forming the write request/pulse pair.
REQ-011 SHALL have register-file-side ports rf_re out 1, rf_r_idx out 5, rf_rack in 1, rf_dout in REG_SZ, rf_we out 1, rf_w_idx out 5, rf_din out REG_SZ, and rf_wack in 1.
REQ-012 SHALL have port err  out  1  one-cycle pulse on an ack timeout.
REQ-013 SHALL have port busy  out  1  high when either channel is not idle.

Function
REQ-014 Read channel FSM SHALL have the states R_IDLE, R_ASSERT, R_RELEASE, R_DONE.
- R_IDLE: grant the winner, latch its index into rf_r_idx, go to R_ASSERT next cycle.
- R_ASSERT: rf_re=1 until rf_rack is sampled 1, then go to R_RELEASE and capture rf_dout.
- R_RELEASE: rf_re=0 until rf_rack is sampled 0, then go to R_DONE.
- R_DONE: pulse rd_done[k], then return to R_IDLE.
REQ-015 Write channel FSM SHALL be identical in form (W_IDLE, W_ASSERT, W_RELEASE, W_DONE), with rf_we/rf_wack; rf_w_idx and rf_din are held stable from W_ASSERT through W_RELEASE.
REQ-016 Minimum latency from a request sampled in IDLE to the done pulse SHALL be 3 cycles (when the ack rises and falls within one cycle).
REQ-017 Read grant SHALL be round-robin over rd_req; after serving k, priority starts at k+1 mod NRD; after reset, requester 0 has top priority.
REQ-018 A requester SHALL hold rd_req and rd_idx stable until its rd_done; dropping rd_req earlier is a protocol violation and the in-flight access still completes.
REQ-019 Reads of index 0 SHALL NOT touch the regfile: rd_data=0 and rd_done pulse the cycle after grant.
REQ-020 Writes to index 0 SHALL be discarded: no rf_we, wr_done pulses the cycle after acceptance.
REQ-021 Read and write channels SHALL run concurrently, except that a read whose index equals the index of a write that is pending or in flight (nonzero) SHALL be ordered after that write.
REQ-022 If a write request and a same-index read request are sampled in the same cycle, the write SHALL win ordering.
REQ-023 Each channel SHALL have its own cycle counter in ASSERT and RELEASE.
- On reaching TMO, the channel drops re/we, pulses err, returns to IDLE and pulses done.
- For reads, rd_data=0 in that done cycle.

Reset
REQ-024 While rst=0, both FSMs SHALL be in IDLE.
REQ-025 While rst=0, rf_re=rf_we=0, rf_r_idx=rf_w_idx=0, rf_din=0, rd_data=0, rd_done=0, wr_done=0, err=0, busy=0, and the round-robin pointer=0.
REQ-026 Reset asserted mid-access SHALL abort the access immediately with no done pulse.

Configuration
REQ-027 Macro REG_PORT_ARB_BYPASS_EN SHALL control same-index read/write handling.
- Defined: a read whose index matches a pending or in-flight write is served from wr_data without a regfile read; rd_done pulses the cycle after grant.
- Undefined: the read stalls in R_IDLE until that write's wr_done, then proceeds normally.

Structure
REQ-028 Package reg_port_arb_pkg SHALL hold IDX_W=5, the default REG_SZ and TMO values, and the read/write state enums.
REQ-029 The round-robin picker SHALL be the sub-module reg_port_arb_rr (inputs: request vector and pointer; outputs: one-hot grant and grant index).

Verification
REQ-030 Write then read: wr_req idx=3 data=0x1234 with instant ack -> wr_done at +3; then rd_req[0] idx=3 -> rd_done[0] at +3 and rd_data=0x1234.
REQ-031 Contention: rd_req=2'b11 held continuously -> grants alternate 0,1,0,1; each served requester sees exactly one rd_done per access.
REQ-032 Index 0: rd idx=0 -> rd_data=0 at +1 with rf_re never high; wr idx=0 data=0xFF -> wr_done at +1 with rf_we never high.
REQ-033 Timeout: rf_rack tied 0 and a read issued -> rf_re high for 15 cycles, then err and rd_done pulse together, with rd_data=0.
REQ-034 Hazard: write idx=5 data=0xAA and read idx=5 in the same cycle -> with BYPASS_EN, rd_data=0xAA at +1 and no rf_re; without it, rd_done comes after wr_done and rd_data=0xAA.
REQ-035 Reset mid-read: rst=0 while in R_ASSERT -> rf_re=0 immediately, no rd_done, busy=0.
